// File: rtl/freq_measure_mc.sv
// Multi-channel gated frequency counter.
// Counts rising edges on NCH asynchronous inputs over a common gate window of
// GATE_n rx_clk cycles and latches saturated per-channel results plus an overflow
// flag. Single-shot or continuous; continuous windows are back-to-back with no
// dead cycle, so every edge pulse lands in exactly one window.
module freq_measure_mc #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned CW     = 32,
  parameter int unsigned TW     = 32,
  parameter int unsigned GATE_0 = 20000,
  parameter int unsigned GATE_1 = 200000,
  parameter int unsigned GATE_2 = 2000000,
  parameter int unsigned GATE_3 = 20000000
) (
  input  logic              rx_clk,
  input  logic              cnt_clr,
  input  logic              start,
  input  logic              stop,
  input  logic              mode_cont,
  input  logic [1:0]        gate_sel,
  input  logic [NCH-1:0]    sig_in,
  output logic              busy,
  output logic              done,
  output logic              status,
  output logic [NCH*CW-1:0] cnt_num,
  output logic [NCH-1:0]    ovf
);

  // Timer is loaded with the window length minus one and the window closes at zero.
  localparam logic [TW-1:0] GateLast0 = TW'(GATE_0 - 1);
  localparam logic [TW-1:0] GateLast1 = TW'(GATE_1 - 1);
  localparam logic [TW-1:0] GateLast2 = TW'(GATE_2 - 1);
  localparam logic [TW-1:0] GateLast3 = TW'(GATE_3 - 1);

  typedef enum logic [0:0] {StIdle, StCount} state_e;

  function automatic logic [TW-1:0] gate_last(input logic [1:0] sel);
    unique case (sel)
      2'd0:    gate_last = GateLast0;
      2'd1:    gate_last = GateLast1;
      2'd2:    gate_last = GateLast2;
      default: gate_last = GateLast3;
    endcase
  endfunction

  logic [NCH-1:0] sync1_q, sync2_q, prev_q;
  logic [NCH-1:0] edge_pulse;

  state_e                 state_q;
  logic [TW-1:0]          timer_q;
  logic [NCH-1:0][CW-1:0] acc_q;
  logic [NCH-1:0][CW-1:0] acc_sum;
  logic [NCH-1:0]         sticky_q;
  logic [NCH-1:0]         sat_hit;
  logic                   busy_q, done_q, status_q;
  logic [NCH-1:0][CW-1:0] cnt_num_q;
  logic [NCH-1:0]         ovf_q;
  logic                   terminal;

  // Two-flop synchroniser per channel, followed by a history flop for edge detection.
  always_ff @(posedge rx_clk or negedge cnt_clr) begin
    if (!cnt_clr) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_pulse = sync2_q & ~prev_q;
  assign terminal   = (timer_q == '0);

  // Saturating accumulate of this cycle's edge pulse; sat_hit flags a lost increment.
  always_comb begin
    sat_hit = '0;
    acc_sum = acc_q;
    for (int k = 0; k < int'(NCH); k++) begin
      sat_hit[k] = edge_pulse[k] & (&acc_q[k]);
      acc_sum[k] = acc_q[k] + {{(CW-1){1'b0}}, edge_pulse[k] & ~(&acc_q[k])};
    end
  end

  // Window control FSM with registered outputs.
  always_ff @(posedge rx_clk or negedge cnt_clr) begin
    if (!cnt_clr) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      acc_q     <= '0;
      sticky_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      status_q  <= 1'b0;
      cnt_num_q <= '0;
      ovf_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // stop takes priority over a simultaneous start
          if (start && !stop) begin
            state_q  <= StCount;
            timer_q  <= gate_last(gate_sel);
            acc_q    <= '0;
            sticky_q <= '0;
            status_q <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        StCount: begin
          if (stop) begin
            // Abort: the partial window is discarded, held results stay untouched.
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (!terminal) begin
            timer_q  <= timer_q - 1'b1;
            acc_q    <= acc_sum;
            sticky_q <= sticky_q | sat_hit;
          end else begin
            // Terminal cycle: its own edge pulse still belongs to this window.
            cnt_num_q <= acc_sum;
            ovf_q     <= sticky_q | sat_hit;
            done_q    <= 1'b1;
            status_q  <= 1'b1;
            if (mode_cont) begin
              timer_q  <= gate_last(gate_sel);
              acc_q    <= '0;
              sticky_q <= '0;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign status  = status_q;
  assign cnt_num = cnt_num_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_freq_measure_mc.sv
// Bench for freq_measure_mc: directed scenarios plus randomized windows, checked
// against a model that counts rising edges from a per-cycle history of sig_in.
module tb_freq_measure_mc;

  localparam int NCH    = 4;
  localparam int CW     = 8;
  localparam int G0     = 100;
  localparam int G1     = 37;
  localparam int G2     = 2;
  localparam int G3     = 1000;
  localparam int MaxCnt = (1 << CW) - 1;
  localparam int HMax   = 20000;

  logic              rx_clk    = 1'b0;
  logic              cnt_clr   = 1'b0;
  logic              start     = 1'b0;
  logic              stop      = 1'b0;
  logic              mode_cont = 1'b0;
  logic [1:0]        gate_sel  = 2'd0;
  logic [NCH-1:0]    sig_in    = '0;
  logic              busy, done, status;
  logic [NCH*CW-1:0] cnt_num;
  logic [NCH-1:0]    ovf;

  freq_measure_mc #(
    .NCH    (NCH),
    .CW     (CW),
    .TW     (32),
    .GATE_0 (G0),
    .GATE_1 (G1),
    .GATE_2 (G2),
    .GATE_3 (G3)
  ) u_dut (
    .rx_clk    (rx_clk),
    .cnt_clr   (cnt_clr),
    .start     (start),
    .stop      (stop),
    .mode_cont (mode_cont),
    .gate_sel  (gate_sel),
    .sig_in    (sig_in),
    .busy      (busy),
    .done      (done),
    .status    (status),
    .cnt_num   (cnt_num),
    .ovf       (ovf)
  );

  always #5 rx_clk = ~rx_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Per-cycle record of the input level seen at each rising edge (0 while in reset).
  logic [NCH-1:0] hist [HMax];
  int cyc = 0;
  always @(posedge rx_clk) begin
    if (cyc < HMax) hist[cyc] <= cnt_clr ? sig_in : '0;
    cyc <= cyc + 1;
  end

  int done_seen = 0;
  always @(negedge rx_clk) begin
    if (done === 1'b1) done_seen <= done_seen + 1;
  end

  // Stimulus driver: per channel 0 = manual level, >0 = period, <0 = random holds.
  int             mode_ch [NCH] = '{default: 0};
  int             ph      [NCH] = '{default: 0};
  int             hold    [NCH] = '{default: 0};
  logic [NCH-1:0] man_val       = '0;
  always @(negedge rx_clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (mode_ch[k] > 0) begin
        ph[k]     <= (ph[k] + 1) % mode_ch[k];
        sig_in[k] <= (((ph[k] + 1) % mode_ch[k]) < (mode_ch[k] / 2));
      end else if (mode_ch[k] < 0) begin
        if (hold[k] <= 1) begin
          sig_in[k] <= ~sig_in[k];
          hold[k]   <= int'($urandom_range(2, 6));
        end else begin
          hold[k] <= hold[k] - 1;
        end
      end else begin
        sig_in[k] <= man_val[k];
      end
    end
  end

  // Reference: a rise sampled at edge t is counted at edge t+2; window covers s+1..s+g.
  function automatic logic hv(input int i, input int k);
    if (i < 0 || i >= HMax) return 1'b0;
    return hist[i][k];
  endfunction

  function automatic int edges_in(input int k, input int lo, input int hi);
    int n = 0;
    for (int u = lo; u <= hi; u++) begin
      if (hv(u - 2, k) && !hv(u - 3, k)) n++;
    end
    return n;
  endfunction

  function automatic int gate_len(input logic [1:0] g);
    case (g)
      2'd0:    return G0;
      2'd1:    return G1;
      2'd2:    return G2;
      default: return G3;
    endcase
  endfunction

  logic [CW-1:0]  e_cnt [NCH];
  logic [NCH-1:0] e_ovf    = '0;
  logic           e_status = 1'b0;

  task automatic check_held(input string tag);
    for (int k = 0; k < NCH; k++) begin
      check_val($sformatf("%s_cnt%0d", tag, k), 64'(cnt_num[k*CW +: CW]), 64'(e_cnt[k]));
    end
    check_val({tag, "_ovf"}, 64'(ovf), 64'(e_ovf));
    check_val({tag, "_status"}, 64'(status), 64'(e_status));
  endtask

  task automatic do_start(input logic [1:0] g, input logic cont, output int s);
    @(negedge rx_clk);
    gate_sel  = g;
    mode_cont = cont;
    start     = 1'b1;
    @(posedge rx_clk);
    #1;
    s        = cyc - 1;
    e_status = 1'b0;
    check_val("start_busy", 64'(busy), 64'd1);
    check_val("start_status", 64'(status), 64'd0);
    @(negedge rx_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int s, input int g, output int d);
    int budget;
    int n;
    budget = g + 4;
    d      = -1;
    while (budget > 0 && d < 0) begin
      @(posedge rx_clk);
      #1;
      if (done === 1'b1) d = cyc - 1;
      budget--;
    end
    check_val({tag, "_gate"}, 64'(d - s), 64'(g));
    if (d >= 0) begin
      for (int k = 0; k < NCH; k++) begin
        n        = edges_in(k, s + 1, s + g);
        e_cnt[k] = (n > MaxCnt) ? CW'(MaxCnt) : CW'(n);
        e_ovf[k] = (n > MaxCnt);
      end
      e_status = 1'b1;
      check_held(tag);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s, d, s0, g, nw, ds;
    longint sum0;
    for (int k = 0; k < NCH; k++) e_cnt[k] = '0;

    // Reset state
    repeat (4) @(negedge rx_clk);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_status", 64'(status), 64'd0);
    check_val("rst_cnt", 64'(cnt_num), 64'd0);
    check_val("rst_ovf", 64'(ovf), 64'd0);
    cnt_clr = 1'b1;

    // 1: single shot, ch0 period 10
    mode_ch[0] = 10;
    repeat (20) @(negedge rx_clk);
    do_start(2'd0, 1'b0, s);
    wait_done("t1", s, G0, d);
    check_val("t1_c0_const", 64'(cnt_num[0 +: CW]), 64'd10);
    check_val("t1_busy", 64'(busy), 64'd0);
    @(posedge rx_clk);
    #1;
    check_val("t1_done_pulse", 64'(done), 64'd0);

    // 2: four channels, continuous for 5 windows
    mode_ch[0] = 4; mode_ch[1] = 10; mode_ch[2] = 20; mode_ch[3] = 0;
    repeat (30) @(negedge rx_clk);
    do_start(2'd0, 1'b1, s);
    s0   = s;
    g    = G0;
    sum0 = 0;
    for (int w = 0; w < 5; w++) begin
      if (w == 4) begin
        @(negedge rx_clk);
        mode_cont = 1'b0;
      end
      wait_done($sformatf("t2_w%0d", w), s, g, d);
      check_val($sformatf("t2_w%0d_c0k", w), 64'(cnt_num[0*CW +: CW]), 64'd25);
      check_val($sformatf("t2_w%0d_c1k", w), 64'(cnt_num[1*CW +: CW]), 64'd10);
      check_val($sformatf("t2_w%0d_c2k", w), 64'(cnt_num[2*CW +: CW]), 64'd5);
      check_val($sformatf("t2_w%0d_c3k", w), 64'(cnt_num[3*CW +: CW]), 64'd0);
      sum0 += longint'(cnt_num[0 +: CW]);
      s = d;
      g = gate_len(gate_sel);
    end
    check_val("t2_sum", 64'(sum0), 64'(edges_in(0, s0 + 1, d)));
    check_val("t2_busy", 64'(busy), 64'd0);

    // 3: saturation on a long gate, then a clean short window
    mode_ch[0] = 3; mode_ch[1] = 0; mode_ch[2] = 0;
    repeat (10) @(negedge rx_clk);
    do_start(2'd3, 1'b0, s);
    wait_done("t3_long", s, G3, d);
    check_val("t3_sat", 64'(cnt_num[0 +: CW]), 64'(MaxCnt));
    check_val("t3_ovf0", 64'(ovf[0]), 64'd1);
    do_start(2'd0, 1'b0, s);
    wait_done("t3_short", s, G0, d);
    check_val("t3_ovf0_clr", 64'(ovf[0]), 64'd0);

    // 4: stop at timer==50, then start+stop together in idle
    mode_ch[0] = 4;
    do_start(2'd0, 1'b0, s);
    repeat (49) @(negedge rx_clk);
    stop = 1'b1;
    @(posedge rx_clk);
    #1;
    check_val("t4_busy_stop", 64'(busy), 64'd0);
    ds = done_seen;
    @(negedge rx_clk);
    stop = 1'b0;
    repeat (120) @(posedge rx_clk);
    #1;
    check_val("t4_no_done", 64'(done_seen), 64'(ds));
    check_held("t4_hold");
    @(negedge rx_clk);
    start = 1'b1;
    stop  = 1'b1;
    @(posedge rx_clk);
    #1;
    check_val("t4_both_busy", 64'(busy), 64'd0);
    @(negedge rx_clk);
    start = 1'b0;
    stop  = 1'b0;
    repeat (5) @(posedge rx_clk);
    #1;
    check_val("t4_both_busy2", 64'(busy), 64'd0);
    check_held("t4_both");

    // 5: 2-cycle windows with an edge on the terminal cycle
    mode_ch[0] = 0;
    man_val    = '0;
    repeat (10) @(negedge rx_clk);
    @(posedge rx_clk);
    #2;
    man_val[1] = 1'b1;
    do_start(2'd2, 1'b1, s);
    wait_done("t5_w0", s, G2, d);
    check_val("t5_term_c1", 64'(cnt_num[1*CW +: CW]), 64'd1);
    @(negedge rx_clk);
    mode_cont = 1'b0;
    s = d;
    wait_done("t5_w1", s, G2, d);
    check_val("t5_next_c1", 64'(cnt_num[1*CW +: CW]), 64'd0);
    check_val("t5_busy", 64'(busy), 64'd0);
    man_val[1] = 1'b0;

    // 6: reset mid-window, restart, start pulses while busy
    mode_ch[0] = 4; mode_ch[1] = 10; mode_ch[2] = -1; mode_ch[3] = 3;
    do_start(2'd0, 1'b0, s);
    repeat (30) @(negedge rx_clk);
    cnt_clr = 1'b0;
    #1;
    check_val("t6_rst_busy", 64'(busy), 64'd0);
    check_val("t6_rst_status", 64'(status), 64'd0);
    check_val("t6_rst_done", 64'(done), 64'd0);
    check_val("t6_rst_cnt", 64'(cnt_num), 64'd0);
    check_val("t6_rst_ovf", 64'(ovf), 64'd0);
    for (int k = 0; k < NCH; k++) e_cnt[k] = '0;
    e_ovf    = '0;
    e_status = 1'b0;
    repeat (3) @(negedge rx_clk);
    cnt_clr = 1'b1;
    @(posedge rx_clk);
    #1;
    check_held("t6_post_rst");
    repeat (5) @(negedge rx_clk);
    do_start(2'd1, 1'b0, s);
    for (int i = 0; i < 3; i++) begin
      repeat (4) @(negedge rx_clk);
      start = 1'b1;
      @(negedge rx_clk);
      start = 1'b0;
    end
    wait_done("t6_restart", s, G1, d);

    // Randomized continuous runs with mid-window gate_sel changes
    for (int k = 0; k < NCH; k++) mode_ch[k] = -1;
    for (int r = 0; r < 4; r++) begin
      repeat (int'($urandom_range(3, 12))) @(negedge rx_clk);
      do_start(2'($urandom_range(0, 2)), 1'b1, s);
      g  = gate_len(gate_sel);
      nw = int'($urandom_range(2, 4));
      for (int w = 0; w < nw; w++) begin
        @(negedge rx_clk);
        gate_sel = 2'($urandom_range(0, 2));
        if (w == nw - 1) mode_cont = 1'b0;
        wait_done($sformatf("rnd%0d_w%0d", r, w), s, g, d);
        s = d;
        g = gate_len(gate_sel);
      end
      check_val($sformatf("rnd%0d_busy", r), 64'(busy), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
